// File: rtl/mesh_noc_pkg.sv
// Shared definitions for the 2D-mesh NoC link components.
// Provides the default flit width, a flit typedef, the skid FIFO depth
// rule and a constant-friendly ceil-log2 helper used for pointer sizing.
package mesh_noc_pkg;

  localparam int LINK_WIDTHS_DEF = 8;

  typedef logic [LINK_WIDTHS_DEF-1:0] flit_t;

  // Room for STAGES flits in the forward pipe, STAGES flits sent while the
  // stop travels back, two cycles of reaction, plus two entries of slack.
  function automatic int skid_depth(input int stages);
    return 2 * stages + 4;
  endfunction

  // Smallest n with 2**n >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/link_skid_fifo.sv
// Receive-side skid FIFO for one link channel.
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   push       - write request; push_data is stored when accepted
//   pop        - read request; ignored while empty
//   pop_data   - head-of-queue entry (combinational read)
//   count      - occupancy 0..DEPTH
//   empty/full - occupancy flags
//   ovf        - sticky: a push was dropped because the FIFO was full
module link_skid_fifo
  import mesh_noc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PW = clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so push-at-full is fine then.
  assign do_push  = push && (!full || do_pop);

  // Pointers wrap at DEPTH, which need not be a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !do_push) ovf <= 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mesh_link_pipe.sv
// Retimed inter-router link bundle: CHANNELS independent flit/wr_en/ON_OFF
// links, each with STAGES forward register slices, a receive-side skid FIFO,
// a drain/output register and a STAGES-deep stop path back to upstream.
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   up_in_flit_flat   - upstream flits, channel c at [c*LINK_WIDTHS +: LINK_WIDTHS]
//   up_in_wr_en       - upstream write strobes
//   up_out_full       - ON_OFF to upstream, 1 = stop sending
//   dn_out_flit_flat  - downstream flits, same packing
//   dn_out_wr_en      - downstream write strobes
//   dn_in_on_off      - downstream ON_OFF, 1 = do not write
//   ovf_sticky        - per-channel dropped-flit flag, cleared only by reset
module mesh_link_pipe
  import mesh_noc_pkg::*;
#(
  parameter int LINK_WIDTHS = LINK_WIDTHS_DEF,
  parameter int CHANNELS    = 1,
  parameter int STAGES      = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [LINK_WIDTHS*CHANNELS-1:0] up_in_flit_flat,
  input  logic [CHANNELS-1:0]             up_in_wr_en,
  output logic [CHANNELS-1:0]             up_out_full,
  output logic [LINK_WIDTHS*CHANNELS-1:0] dn_out_flit_flat,
  output logic [CHANNELS-1:0]             dn_out_wr_en,
  input  logic [CHANNELS-1:0]             dn_in_on_off,
  output logic [CHANNELS-1:0]             ovf_sticky
);

  localparam int SKID_DEPTH  = skid_depth(STAGES);
  localparam int CW          = clog2(SKID_DEPTH) + 1;
  localparam int STOP_MARGIN = 2 * STAGES + 2;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [STAGES-1:0]      stg_valid;
    logic [LINK_WIDTHS-1:0] stg_flit [STAGES];
    logic [LINK_WIDTHS-1:0] pop_data;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic                   empty;
    logic                   full;
    logic                   pop;
    logic                   accepted;
    logic                   out_valid;
    logic [LINK_WIDTHS-1:0] out_flit;
    logic [STAGES-1:0]      stop_pipe;

    // Flit bits only load with a valid strobe, so idle cycles cost no toggles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stg_valid <= '0;
        for (int s = 0; s < STAGES; s++) stg_flit[s] <= '0;
      end else begin
        stg_valid[0] <= up_in_wr_en[c];
        if (up_in_wr_en[c]) stg_flit[0] <= up_in_flit_flat[c*LINK_WIDTHS +: LINK_WIDTHS];
        for (int s = 1; s < STAGES; s++) begin
          stg_valid[s] <= stg_valid[s-1];
          if (stg_valid[s-1]) stg_flit[s] <= stg_flit[s-1];
        end
      end
    end

    assign pop = !empty && !dn_in_on_off[c];

    link_skid_fifo #(
      .WIDTH (LINK_WIDTHS),
      .DEPTH (SKID_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (stg_valid[STAGES-1]),
      .push_data (stg_flit[STAGES-1]),
      .pop       (pop),
      .pop_data  (pop_data),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .ovf       (ovf_sticky[c])
    );

    // Mirror of the FIFO's own accept rule, so the stop decision sees the
    // occupancy the FIFO will hold after this edge.
    assign accepted = stg_valid[STAGES-1] && (!full || pop);

    always_comb begin
      count_next = count;
      if (accepted && !pop)      count_next = count + CW'(1);
      else if (!accepted && pop) count_next = count - CW'(1);
    end

    // Output register: flit holds its last value when nothing is popped.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid <= 1'b0;
        out_flit  <= '0;
      end else begin
        out_valid <= pop;
        if (pop) out_flit <= pop_data;
      end
    end

    // stop_pipe[0] is the registered stop; the rest retime it over the
    // backward wire so upstream sees occupancy STAGES cycles later.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stop_pipe <= '0;
      end else begin
        stop_pipe[0] <= (SKID_DEPTH - int'(count_next)) <= STOP_MARGIN;
        for (int s = 1; s < STAGES; s++) stop_pipe[s] <= stop_pipe[s-1];
      end
    end

    assign up_out_full[c]                                     = stop_pipe[STAGES-1];
    assign dn_out_wr_en[c]                                    = out_valid;
    assign dn_out_flit_flat[c*LINK_WIDTHS +: LINK_WIDTHS]     = out_flit;
  end

endmodule
